// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants for the 4x4 matrix keypad scanner.
// Holds the scanner state codes, the row/column key map, and small helpers
// for classifying a sampled row pattern.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Scanner states, kept as plain constants so older tooling can read them.
  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  // Hex code printed on each key, indexed [row][col].
  localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // True when exactly one active-low row line is pulled down.
  function automatic logic single_low(input logic [NUM_ROWS-1:0] r);
    int zeros;
    zeros = 0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (!r[i]) zeros++;
    end
    return (zeros == 1);
  endfunction

  // Index of the lowest row line that is pulled down.
  function automatic logic [1:0] low_index(input logic [NUM_ROWS-1:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for signals arriving asynchronously to clk.
// Resets to all-ones so idle pulled-up lines read as inactive from the start.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces press and
// release, and reports the hex code of each accepted key with a one-cycle
// key_valid strobe. key_held stays high for as long as the key is down.
// Optional build macro KEYPAD_AUTOREPEAT_EN re-strobes key_valid every
// REPEAT_CYCLES while a key is held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 24000,
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int REPEAT_CYCLES   = 4800000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       col_idx;
  logic [1:0]       row_idx;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       rows_s;
  logic [3:0]       row_pattern;
  logic             repeat_fire;

  sync_2ff #(.WIDTH(NUM_ROWS)) u_rows_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  // The column index only moves while scanning, so the drive freezes on its own.
  assign cols        = ~(4'b0001 << col_idx);
  assign row_pattern = ~(4'b0001 << row_idx);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt;

  assign repeat_fire = (state == HELD) && !rows_s[row_idx] && (rpt_cnt == RPT_LAST);

  // Repeat timer runs only while the key stays down in HELD; anything else zeroes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt <= '0;
    end else if ((state == HELD) && !rows_s[row_idx]) begin
      rpt_cnt <= (rpt_cnt == RPT_LAST) ? '0 : rpt_cnt + 1'b1;
    end else begin
      rpt_cnt <= '0;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  // Scan / debounce / hold / release sequencing and the key output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      cnt       <= '0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (single_low(rows_s)) begin
              row_idx <= low_index(rows_s);
              state   <= DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (rows_s != row_pattern) begin
            cnt   <= '0;
            state <= SCAN;
          end else if (cnt == DEB_LAST) begin
            cnt       <= '0;
            key       <= KEY_MAP[row_idx][col_idx];
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (rows_s[row_idx]) begin
            cnt   <= '0;
            state <= RELEASE;
          end else if (repeat_fire) begin
            key_valid <= 1'b1;
          end
        end
        RELEASE: begin
          if (!rows_s[row_idx]) begin
            cnt   <= '0;
            state <= HELD;
          end else if (cnt == DEB_LAST) begin
            cnt      <= '0;
            key_held <= 1'b0;
            col_idx  <= col_idx + 2'd1;
            state    <= SCAN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a simulated keypad matrix (pressed keys short a
// row to the active column) and checks every cycle against a deadline-based
// model of the scanner, plus literal timing pins for directed scenarios.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int REP      = 16;

  localparam int P_SCAN = 0;
  localparam int P_DEB  = 1;
  localparam int P_HELD = 2;
  localparam int P_REL  = 3;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Physical keypad: which switches are closed, plus optional forced glitches.
  bit         pressed [4][4];
  int         glitch_at = -1;
  logic [3:0] glitch_val = 4'hF;
  bit         rand_glitch_en = 1'b0;

  int key_map [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  // Reference model: phase plus absolute-cycle deadlines.
  int         mk;
  int         m_ph, m_col, m_row, m_deadline, m_rpt;
  logic [3:0] h1, h2;
  logic [3:0] exp_cols, exp_key;
  logic       exp_valid, exp_held;

  // Observations for the literal pins.
  int         strobe_count, first_strobe, fall_cycle;
  logic [3:0] key_at_first, cols_at_fall;
  logic       prev_held;

  task automatic check_output(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int zeros(input logic [3:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (!v[i]) n++;
    return n;
  endfunction

  function automatic logic [3:0] col_drive(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic model_reset();
    mk = 0; m_ph = P_SCAN; m_col = 0; m_row = 0;
    m_deadline = SCAN_DIV - 1; m_rpt = 0;
    h1 = 4'hF; h2 = 4'hF;
    exp_cols = col_drive(0); exp_key = 4'h0; exp_valid = 1'b0; exp_held = 1'b0;
  endtask

  task automatic clear_stats();
    strobe_count = 0; first_strobe = -1; fall_cycle = -1;
    key_at_first = 4'h0; cols_at_fall = 4'h0; prev_held = 1'b0;
  endtask

  // Advance the model by one cycle given the rows driven in cycle mk.
  task automatic model_step(input logic [3:0] r);
    logic [3:0] rs;
    logic       match;
    rs = h2; h2 = h1; h1 = r;
    exp_valid = 1'b0;
    if (m_ph == P_SCAN) begin
      if (mk == m_deadline) begin
        if (zeros(rs) == 1) begin
          for (int i = 3; i >= 0; i--) if (!rs[i]) m_row = i;
          m_ph = P_DEB;
          m_deadline = mk + DEB;
        end else begin
          m_col = (m_col + 1) % 4;
          m_deadline = mk + SCAN_DIV;
        end
      end
    end else if (m_ph == P_DEB) begin
      match = (zeros(rs) == 1) && !rs[m_row];
      if (!match) begin
        m_ph = P_SCAN;
        m_deadline = mk + SCAN_DIV;
      end else if (mk == m_deadline) begin
        exp_key = 4'(key_map[m_row][m_col]);
        exp_valid = 1'b1;
        exp_held = 1'b1;
        m_ph = P_HELD;
        m_rpt = mk + REP;
      end
    end else if (m_ph == P_HELD) begin
      if (rs[m_row]) begin
        m_ph = P_REL;
        m_deadline = mk + DEB;
      end else if (AUTOREPEAT && mk == m_rpt) begin
        exp_valid = 1'b1;
        m_rpt = mk + REP;
      end
    end else begin
      if (!rs[m_row]) begin
        m_ph = P_HELD;
        m_rpt = mk + REP;
      end else if (mk == m_deadline) begin
        exp_held = 1'b0;
        m_col = (m_col + 1) % 4;
        m_ph = P_SCAN;
        m_deadline = mk + SCAN_DIV;
      end
    end
    mk++;
    exp_cols = col_drive(m_col);
  endtask

  // Resolve the matrix against the current column drive, then step the model.
  task automatic apply_stimulus();
    logic [3:0] r;
    r = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (pressed[rr][cc] && !cols[cc]) r[rr] = 1'b0;
    if (mk == glitch_at) r = glitch_val;
    if (rand_glitch_en && $urandom_range(15) == 0) r = 4'($urandom);
    rows = r;
    model_step(r);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      apply_stimulus();
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_keys();
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        pressed[rr][cc] = 1'b0;
  endtask

  // Reset takes effect immediately; outputs are pinned to literals right away.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("reset_cols", int'(cols), 'hE);
    check_output("reset_key", int'(key), 0);
    check_output("reset_valid", int'(key_valid), 0);
    check_output("reset_held", int'(key_held), 0);
    model_reset();
    clear_stats();
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus();
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(posedge clk) begin
    #1;
    check_output("cols", int'(cols), int'(exp_cols));
    check_output("key", int'(key), int'(exp_key));
    check_output("key_valid", int'(key_valid), int'(exp_valid));
    check_output("key_held", int'(key_held), int'(exp_held));
    if (key_valid) begin
      strobe_count++;
      if (first_strobe < 0) begin
        first_strobe = mk;
        key_at_first = key;
      end
    end
    if (prev_held && !key_held) begin
      fall_cycle = mk;
      cols_at_fall = cols;
    end
    prev_held = key_held;
  end

  initial begin
    reset = 1'b1;
    rows = 4'hF;
    clear_keys();
    model_reset();
    clear_stats();

    // Idle rotation, no strobes.
    do_reset();
    run_cycles(20);
    settle();
    check_output("idle_strobes", strobe_count, 0);

    // Hold '6' steadily.
    pressed[1][2] = 1'b1;
    do_reset();
    run_cycles(61);
    settle();
    check_output("hold6_first_cycle", first_strobe, 20);
    check_output("hold6_key", int'(key_at_first), 6);
    check_output("hold6_strobes", strobe_count, AUTOREPEAT ? 3 : 1);
    check_output("hold6_held", int'(key_held), 1);
    check_output("hold6_cols", int'(cols), 'hB);

    // Bounce during debounce restarts from the same column.
    glitch_at = 13; glitch_val = 4'hF;
    do_reset();
    run_cycles(40);
    settle();
    check_output("bounce_first_cycle", first_strobe, 28);
    check_output("bounce_strobes", strobe_count, 1);
    glitch_at = -1;

    // Two rows low on column 0: rejected.
    clear_keys();
    pressed[0][0] = 1'b1; pressed[2][0] = 1'b1;
    do_reset();
    run_cycles(40);
    settle();
    check_output("ghost_strobes", strobe_count, 0);
    check_output("ghost_held", int'(key_held), 0);

    // Release with a low glitch partway through the release window.
    clear_keys();
    pressed[1][2] = 1'b1;
    do_reset();
    run_cycles(29);
    clear_keys();
    glitch_at = 34; glitch_val = 4'b1101;
    run_cycles(20);
    settle();
    glitch_at = -1;
    check_output("release_fall_cycle", fall_cycle, 46);
    check_output("release_cols", int'(cols_at_fall), 'h7);
    check_output("release_strobes", strobe_count, 1);

    // Reset while debouncing.
    pressed[1][2] = 1'b1;
    do_reset();
    run_cycles(15);
    settle();
    check_output("mid_reset_pre_strobes", strobe_count, 0);
    clear_keys();
    do_reset();
    run_cycles(20);
    settle();
    check_output("mid_reset_post_strobes", strobe_count, 0);

    // Randomized presses, multi-presses and glitches.
    rand_glitch_en = 1'b1;
    for (int ep = 0; ep < 40; ep++) begin
      int mode;
      if ($urandom_range(9) == 0) do_reset();
      mode = $urandom_range(3);
      clear_keys();
      if (mode != 0) pressed[$urandom_range(3)][$urandom_range(3)] = 1'b1;
      if (mode == 3) pressed[$urandom_range(3)][$urandom_range(3)] = 1'b1;
      run_cycles($urandom_range(70, 10));
      clear_keys();
      run_cycles($urandom_range(40, 5));
    end
    rand_glitch_en = 1'b0;
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the seven-segment output path: scans a 4x4 matrix keypad, debounces presses, and produces a 4-bit hex code plus a one-cycle valid strobe.
- Sits between the board keypad pins and the hex-to-seven-segment decode logic in the top level.
- Runs on the 24 MHz HSOSC clock.

Parameters:
- SCAN_DIV, 24000: clock cycles each column is driven before its rows are sampled (1 ms at 24 MHz); must be >= 4.
- DEBOUNCE_CYCLES, 480000: cycles a press or release must be continuously stable to be accepted (20 ms).
- REPEAT_CYCLES, 4800000: auto-repeat interval when KEYPAD_AUTOREPEAT_EN is defined (200 ms).

Ports:
- clk  input  1  system clock (24 MHz internal oscillator).
- reset  input  1  asynchronous, active-high reset.
- rows  input  4  keypad row lines; active-low, externally pulled up; asynchronous to clk.
- cols  output  4  keypad column drive; active-low one-hot.
- key  output  4  hex code of the last accepted key; held until the next accept.
- key_valid  output  1  one-cycle strobe when key is updated.
- key_held  output  1  high from accept until release is debounced.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: cols=4'b1110, key=4'h0, key_valid=0, key_held=0, state=SCAN, column index 0, all counters 0, row synchronizer 4'hF.
- Synchronization: rows passes through a 2-flop synchronizer (rows_s). All decisions use rows_s.
- Key map, indexed [row][col]:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- SCAN state:
  - cols drives column index c low.
  - The dwell counter runs 0..SCAN_DIV-1. rows_s is sampled only on the last dwell cycle.
  - Exactly one row low: latch row r and column c, freeze cols, clear the counter, go to DEBOUNCE.
  - No row low, or two or more rows low (ghosting or multi-press): advance c (3 wraps to 0), keep scanning.
- DEBOUNCE state:
  - Each cycle, rows_s must equal the latched one-hot-low pattern.
  - Any mismatch: back to SCAN, same column, dwell counter cleared, no strobe.
  - Counter reaches DEBOUNCE_CYCLES-1: key=map[r][c], key_valid=1 for exactly that cycle, key_held=1, go to HELD.
  - Latency: key_valid fires DEBOUNCE_CYCLES cycles after the detecting sample.
- HELD state:
  - cols stays frozen.
  - Other rows going low are ignored (no rollover).
  - rows_s[r]==1: clear the counter, go to RELEASE.
- RELEASE state:
  - rows_s[r] must stay high for DEBOUNCE_CYCLES consecutive cycles.
  - rows_s[r] low again: back to HELD, no new strobe, key_held stays 1.
  - Complete: key_held=0, c advances to the next column, go to SCAN.
- Simultaneous events: the release check has priority over the auto-repeat timer in the same cycle.
- Reset mid-operation: immediately forces the reset values; no strobe is emitted for an in-progress press.
- Counter widths: $clog2 of the largest parameter. No counter overflows; each counter saturates at its terminal value only on the state transition.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In HELD, a repeat counter starts at entry.
  - Every REPEAT_CYCLES cycles, key_valid pulses once with the unchanged key.
  - The counter resets on leaving HELD.
- Undefined: exactly one key_valid per accepted press; no repeat counter is synthesized.

Decomposition:
- Package keypad_pkg:
  - state enum {SCAN, DEBOUNCE, HELD, RELEASE}.
  - 4x4 key-map constant array of logic [3:0].
  - NUM_ROWS=4, NUM_COLS=4.
- Sub-module sync_2ff: parameterized-width 2-flop synchronizer with asynchronous active-high reset to all-ones. Instantiated once for rows.
- FSM, counters and latches stay in keypad_scanner.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=16.
- Reset, idle rows=4'hF -> cols=1110, key=0, key_valid=0. cols then rotates 1110→1101→1011→0111→1110, changing every 4 cycles, with no strobes.
- Hold key '6' (row1 low whenever cols=1011) steady -> cols freezes at 1011, key_held rises, a single key_valid with key=4'h6 occurs 8 cycles after detection, and no further strobes while held (macro off).
- Bouncy press: row1 toggles high at debounce cycle 3 -> no strobe and scanning resumes on the same column. Once stable, exactly one strobe with key=6.
- Rows 0 and 2 both low on column 0 -> no strobe, no freeze, cols keeps rotating.
- Release with a glitch low at release cycle 4 -> no second strobe. key_held falls only after 8 continuous high cycles, then cols=0111 (next column).
- Assert reset during DEBOUNCE -> outputs return to reset values at once, no key_valid.
- With KEYPAD_AUTOREPEAT_EN defined, hold '6' for 40 cycles past accept -> key_valid at accept, +16 and +32, key=6 each time.
